// File: rtl/cic_decim_ctrl.sv
// Flush/settle/run sequencer wrapped around one cic_decimator instance.
// Optional sample counter output enabled by defining CIC_CTRL_SAMPLE_COUNT_EN.
module cic_decim_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STAGES       = 3,
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned BURST_WIDTH  = 16,
    parameter int unsigned DROP_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [BURST_WIDTH-1:0] cfg_burst_len,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  cic_data_in,
    output logic                   cic_valid,
    output logic                   cic_flush_n,
    input  logic [DATA_WIDTH-1:0]  cic_data_out,
    input  logic                   cic_out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   done,
    output logic                   busy,
    output logic [1:0]             state_o,
    output logic [DROP_WIDTH-1:0]  drop_cnt
`ifdef CIC_CTRL_SAMPLE_COUNT_EN
    ,
    output logic [31:0]            sample_cnt
`endif
);

    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned SW = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FLUSH  = 2'b01,
        SETTLE = 2'b10,
        RUN    = 2'b11
    } state_t;

    state_t                 state;
    logic [FW-1:0]          flush_cnt;
    logic [SW-1:0]          settle_cnt;
    logic [BURST_WIDTH-1:0] burst_len;
    logic [BURST_WIDTH-1:0] out_cnt;
    logic                   burst_end;

    assign state_o     = state;
    assign busy        = (state != IDLE);
    assign in_ready    = (state == SETTLE) || (state == RUN);
    assign cic_flush_n = (state == SETTLE) || (state == RUN);

    assign burst_end = (state == RUN) && cic_out_valid && !stop &&
                       (burst_len != '0) &&
                       (out_cnt == burst_len - BURST_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            settle_cnt  <= '0;
            burst_len   <= '0;
            out_cnt     <= '0;
            cic_data_in <= '0;
            cic_valid   <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            drop_cnt    <= '0;
`ifdef CIC_CTRL_SAMPLE_COUNT_EN
            sample_cnt  <= '0;
`endif
        end else begin
            out_valid   <= 1'b0;
            done        <= 1'b0;
            cic_data_in <= in_data;
            // Suppress the forward on cycles that leave RUN/SETTLE so the CIC
            // never sees a valid while its flush is asserted.
            cic_valid   <= in_valid && in_ready && !stop && !burst_end;

            if (state == IDLE && start && !stop)
                drop_cnt <= '0;
            else if (in_valid && !in_ready && busy && drop_cnt != '1)
                drop_cnt <= drop_cnt + DROP_WIDTH'(1);

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                        burst_len <= cfg_burst_len;
`ifdef CIC_CTRL_SAMPLE_COUNT_EN
                        sample_cnt <= '0;
`endif
                    end
                end
                FLUSH: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                SETTLE: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (cic_out_valid) begin
                        if (settle_cnt == SW'(STAGES - 1)) begin
                            state   <= RUN;
                            out_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (cic_out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= cic_data_out;
`ifdef CIC_CTRL_SAMPLE_COUNT_EN
                        sample_cnt <= sample_cnt + 32'd1;
`endif
                        if (burst_end) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (burst_len != '0) begin
                            out_cnt <= out_cnt + BURST_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl; second instance exercises drop counter saturation.
module tb_cic_decim_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic [15:0] cfg_burst_len = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [31:0] cic_data_out = '0;
    logic        cic_out_valid = 1'b0;

    logic        in_ready, cic_valid, cic_flush_n, out_valid, done, busy;
    logic [31:0] cic_data_in, out_data;
    logic [1:0]  state_o;
    logic [7:0]  drop_cnt;

    logic        in_ready2, cic_valid2, cic_flush_n2, out_valid2, done2, busy2;
    logic [31:0] cic_data_in2, out_data2;
    logic [1:0]  state_o2;
    logic [1:0]  drop_cnt2;
`ifdef CIC_CTRL_SAMPLE_COUNT_EN
    logic [31:0] sample_cnt, sample_cnt2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cic_decim_ctrl #(.DATA_WIDTH(32), .STAGES(3), .FLUSH_CYCLES(4),
                     .BURST_WIDTH(16), .DROP_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_burst_len(cfg_burst_len), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cic_data_in(cic_data_in), .cic_valid(cic_valid),
        .cic_flush_n(cic_flush_n), .cic_data_out(cic_data_out),
        .cic_out_valid(cic_out_valid), .out_data(out_data), .out_valid(out_valid),
        .done(done), .busy(busy), .state_o(state_o), .drop_cnt(drop_cnt)
`ifdef CIC_CTRL_SAMPLE_COUNT_EN
        , .sample_cnt(sample_cnt)
`endif
    );

    cic_decim_ctrl #(.DATA_WIDTH(32), .STAGES(3), .FLUSH_CYCLES(6),
                     .BURST_WIDTH(16), .DROP_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_burst_len(cfg_burst_len), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .cic_data_in(cic_data_in2), .cic_valid(cic_valid2),
        .cic_flush_n(cic_flush_n2), .cic_data_out(cic_data_out),
        .cic_out_valid(cic_out_valid), .out_data(out_data2), .out_valid(out_valid2),
        .done(done2), .busy(busy2), .state_o(state_o2), .drop_cnt(drop_cnt2)
`ifdef CIC_CTRL_SAMPLE_COUNT_EN
        , .sample_cnt(sample_cnt2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] v);
        cic_out_valid = 1'b1;
        cic_data_out  = v;
        step();
        cic_out_valid = 1'b0;
    endtask

    task automatic wait_settle(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (state_o == 2'b10) break;
            step();
        end
        check(tag, 64'(state_o), 64'd2);
    endtask

    initial begin
        int n_low;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_flush_n", 64'(cic_flush_n), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outs", {in_ready, cic_valid, out_valid, done}, 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Continuous capture, inputs held valid through FLUSH
        cfg_burst_len = 16'd0;
        in_valid = 1'b1;
        in_data  = 32'hABCD;
        pulse_start();
        check("flush_entry", 64'(state_o), 64'd1);
        n_low = 0;
        for (int i = 0; i < 20; i++) begin
            if (state_o == 2'b10) break;
            if (state_o == 2'b01 && !cic_flush_n) n_low++;
            step();
        end
        check("flush_len", 64'(n_low), 64'd4);
        check("settle_flush_n", 64'(cic_flush_n), 64'd1);
        check("settle_ready", 64'(in_ready), 64'd1);
        check("drop_flush", 64'(drop_cnt), 64'd4);
        step();
        check("fwd_valid", 64'(cic_valid), 64'd1);
        check("fwd_data", 64'(cic_data_in), 64'hABCD);
        for (int i = 0; i < 20; i++) begin
            if (state_o2 == 2'b10) break;
            step();
        end
        check("dut2_settle", 64'(state_o2), 64'd2);
        check("drop_sat", 64'(drop_cnt2), 64'd3);
        in_valid = 1'b0;

        push(32'd10); check("disc10", 64'(out_valid), 64'd0);
        push(32'd20); check("disc20", 64'(out_valid), 64'd0);
        push(32'd30); check("disc30", 64'(out_valid), 64'd0);
        check("run_state", 64'(state_o), 64'd3);
        push(32'd40);
        check("out40_v", 64'(out_valid), 64'd1);
        check("out40_d", 64'(out_data), 64'd40);
        step();
        check("pulse_low", 64'(out_valid), 64'd0);
        push(32'd50);
        check("out50_v", 64'(out_valid), 64'd1);
        check("out50_d", 64'(out_data), 64'd50);
        check("cont_busy", 64'(busy), 64'd1);
        check("cont_done", 64'(done), 64'd0);

        // Stop in RUN with a sample offered the same cycle
        stop = 1'b1; in_valid = 1'b1;
        step();
        stop = 1'b0; in_valid = 1'b0;
        check("stop_state", 64'(state_o), 64'd0);
        check("stop_ready", 64'(in_ready), 64'd0);
        check("stop_cic_valid", 64'(cic_valid), 64'd0);
        step();

        // Burst of 2
        cfg_burst_len = 16'd2;
        pulse_start();
        check("drop_cleared", 64'(drop_cnt), 64'd0);
        wait_settle("burst_settle");
        push(32'd1); push(32'd2); push(32'd3);
        push(32'd4);
        check("b4_v", 64'(out_valid), 64'd1);
        check("b4_d", 64'(out_data), 64'd4);
        check("b4_done", 64'(done), 64'd0);
        push(32'd5);
        check("b5_v", 64'(out_valid), 64'd1);
        check("b5_d", 64'(out_data), 64'd5);
        check("b5_done", 64'(done), 64'd1);
        check("b5_state", 64'(state_o), 64'd0);
        push(32'd6);
        check("b6_v", 64'(out_valid), 64'd0);
        check("b6_done", 64'(done), 64'd0);
        step();

        // start+stop together in IDLE
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("ss_state", 64'(state_o), 64'd0);
        check("ss_busy", 64'(busy), 64'd0);

        // stop in SETTLE, CIC output in the stop cycle dropped
        cfg_burst_len = 16'd1;
        pulse_start();
        wait_settle("stop_settle_wait");
        push(32'd7);
        stop = 1'b1;
        push(32'd8);
        stop = 1'b0;
        check("ssettle_state", 64'(state_o), 64'd0);
        check("ssettle_ov", 64'(out_valid), 64'd0);
        check("ssettle_done", 64'(done), 64'd0);
        step();

`ifdef CIC_CTRL_SAMPLE_COUNT_EN
        for (int b = 0; b < 2; b++) begin
            cfg_burst_len = 16'd3;
            pulse_start();
            check("scnt_clear", 64'(sample_cnt), 64'd0);
            wait_settle("scnt_settle");
            for (int k = 1; k <= 6; k++) push(32'(k));
            check("scnt_done", 64'(done), 64'd1);
            check("scnt_val", 64'(sample_cnt), 64'd3);
            step();
        end
`endif

        // Asynchronous reset mid-RUN
        cfg_burst_len = 16'd0;
        pulse_start();
        wait_settle("rstrun_settle");
        push(32'd1); push(32'd2); push(32'd3);
        push(32'd77);
        check("rstrun_ov_pre", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstrun_flush_n", 64'(cic_flush_n), 64'd0);
        check("rstrun_ov", 64'(out_valid), 64'd0);
        check("rstrun_busy", 64'(busy), 64'd0);
        check("rstrun_state", 64'(state_o), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
